// File: rtl/ofs_plat_ccip_c0tx_req_buf_pkg.sv
// Shared definitions for the buffered CCI-P channel 0 read-request stage:
// header layout, default sizes and the occupancy counter type.
package ofs_plat_ccip_c0tx_req_buf_pkg;

    // Channel 0 memory read-request header, MSB first as it appears on sTx.c0.hdr.
    typedef struct packed {
        logic [1:0]  vc_sel;
        logic [1:0]  rsvd1;
        logic [1:0]  cl_len;
        logic [3:0]  req_type;
        logic [5:0]  rsvd0;
        logic [41:0] address;
        logic [15:0] mdata;
    } t_c0tx_req_hdr;

    localparam int C0TX_HDR_WIDTH = $bits(t_c0tx_req_hdr);
    localparam int C0TX_BUF_DEPTH = 8;

    // Counter width that can represent every value 0..depth inclusive.
    function automatic int c0tx_cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef logic [c0tx_cnt_width(C0TX_BUF_DEPTH)-1:0] t_c0tx_buf_cnt;

endpackage

// File: rtl/ofs_plat_prim_fifo_lutram.sv
// DEPTH x WIDTH storage with registered pointers and a combinational read at
// the read pointer. Flow control (full/empty) is the caller's responsibility.
module ofs_plat_prim_fifo_lutram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 74
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;

    // Storage array; left unreset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
        end else begin
            if (i_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/ofs_plat_ccip_c0tx_req_buf.sv
// Buffered CCI-P c0 Tx read-request stage: AFU valid/ready push side, FIFO,
// and registered issue toward the FIU that stops while c0TxAlmFull is high.
module ofs_plat_ccip_c0tx_req_buf
    import ofs_plat_ccip_c0tx_req_buf_pkg::*;
#(
    parameter int DEPTH     = C0TX_BUF_DEPTH,
    parameter int HDR_WIDTH = C0TX_HDR_WIDTH,
    parameter int CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   afu_req_valid,
    input  logic [HDR_WIDTH-1:0]   afu_req_hdr,
    output logic                   afu_req_ready,
    output logic                   fiu_c0Tx_valid,
    output logic [HDR_WIDTH-1:0]   fiu_c0Tx_hdr,
    input  logic                   fiu_c0TxAlmFull,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [CNT_WIDTH-1:0]   issued_cnt
);
    localparam int OCC_W = c0tx_cnt_width(DEPTH);

    logic [OCC_W-1:0]     r_occ;
    logic                 r_valid;
    logic [HDR_WIDTH-1:0] r_hdr;
    logic [CNT_WIDTH-1:0] r_issued_cnt;

    logic                 w_ready;
    logic                 w_push;
    logic                 w_issue_go;
    logic [HDR_WIDTH-1:0] w_rd_data;

    // Full blocks pushes even when a pop happens the same cycle (no bypass).
    assign w_ready    = (r_occ != OCC_W'(DEPTH));
    assign w_push     = afu_req_valid && w_ready;
    assign w_issue_go = (r_occ != {OCC_W{1'b0}}) && !fiu_c0TxAlmFull;

    ofs_plat_prim_fifo_lutram #(
        .DEPTH (DEPTH),
        .WIDTH (HDR_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_push),
        .i_wr_data (afu_req_hdr),
        .i_rd_en   (w_issue_go),
        .o_rd_data (w_rd_data)
    );

    // Entry count: simultaneous push and pop cancel out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_occ <= {OCC_W{1'b0}};
        end else begin
            case ({w_push, w_issue_go})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // FIU-facing registers: valid is a one-cycle pulse, header holds between issues.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_hdr   <= {HDR_WIDTH{1'b0}};
        end else begin
            r_valid <= w_issue_go;
            if (w_issue_go) begin
                r_hdr <= w_rd_data;
            end
        end
    end

    // Issued-request counter, wraps at its width.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_issued_cnt <= {CNT_WIDTH{1'b0}};
        end else if (w_issue_go) begin
            r_issued_cnt <= r_issued_cnt + CNT_WIDTH'(1);
        end
    end

    assign afu_req_ready  = w_ready;
    assign fiu_c0Tx_valid = r_valid;
    assign fiu_c0Tx_hdr   = r_hdr;
    assign occupancy      = r_occ;
    assign issued_cnt     = r_issued_cnt;

endmodule

// File: tb/tb_ofs_plat_ccip_c0tx_req_buf.sv
// Table-driven directed bench for ofs_plat_ccip_c0tx_req_buf plus hand-written
// sequences for almost-full toggling, asynchronous reset and counter wrap.
module tb_ofs_plat_ccip_c0tx_req_buf;
    import ofs_plat_ccip_c0tx_req_buf_pkg::*;

    localparam int HW    = C0TX_HDR_WIDTH;
    localparam int OCC_W = c0tx_cnt_width(C0TX_BUF_DEPTH);
    localparam int NV    = 30;

    logic              clk = 1'b0;
    logic              reset;
    logic              afu_req_valid;
    logic [HW-1:0]     afu_req_hdr;
    logic              afu_req_ready;
    logic              fiu_c0Tx_valid;
    logic [HW-1:0]     fiu_c0Tx_hdr;
    logic              fiu_c0TxAlmFull;
    logic [OCC_W-1:0]  occupancy;
    logic [15:0]       issued_cnt;

    int n_total  = 0;
    int n_passed = 0;

    ofs_plat_ccip_c0tx_req_buf #(
        .DEPTH     (8),
        .HDR_WIDTH (HW),
        .CNT_WIDTH (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .afu_req_valid   (afu_req_valid),
        .afu_req_hdr     (afu_req_hdr),
        .afu_req_ready   (afu_req_ready),
        .fiu_c0Tx_valid  (fiu_c0Tx_valid),
        .fiu_c0Tx_hdr    (fiu_c0Tx_hdr),
        .fiu_c0TxAlmFull (fiu_c0TxAlmFull),
        .occupancy       (occupancy),
        .issued_cnt      (issued_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             v;
        logic [HW-1:0]    h;
        logic             af;
        logic             e_rdy;
        logic             e_val;
        logic [HW-1:0]    e_hdr;
        logic [OCC_W-1:0] e_occ;
        logic [15:0]      e_cnt;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic v, input int h, input logic af,
                                input logic rdy, input logic val, input int eh,
                                input int occ, input int cnt);
        vec_t r;
        r.v     = v;
        r.h     = HW'(h);
        r.af    = af;
        r.e_rdy = rdy;
        r.e_val = val;
        r.e_hdr = HW'(eh);
        r.e_occ = OCC_W'(occ);
        r.e_cnt = 16'(cnt);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end else begin
            n_passed++;
        end
    endtask

    logic [HW-1:0] mq [$];
    logic          exp_iss;
    logic [HW-1:0] exp_h;
    logic          mdl_rdy;
    int            nxt;
    int            pushed;

    initial begin
        // Vector table: inputs for the cycle, and the outputs seen before that cycle's edge.
        vecs[0] = mk(1'b1, 1, 1'b0, 1'b1, 1'b0, 0, 0, 0);
        vecs[1] = mk(1'b1, 2, 1'b0, 1'b1, 1'b0, 0, 1, 0);
        vecs[2] = mk(1'b1, 3, 1'b0, 1'b1, 1'b1, 1, 1, 1);
        vecs[3] = mk(1'b0, 0, 1'b0, 1'b1, 1'b1, 2, 1, 2);
        vecs[4] = mk(1'b0, 0, 1'b0, 1'b1, 1'b1, 3, 0, 3);
        vecs[5] = mk(1'b0, 0, 1'b0, 1'b1, 1'b0, 3, 0, 3);
        for (int k = 0; k < 8; k++) begin
            vecs[6+k] = mk(1'b1, 16 + k, 1'b1, 1'b1, 1'b0, 3, k, 3);
        end
        vecs[14] = mk(1'b1, 24, 1'b1, 1'b0, 1'b0, 3, 8, 3);
        vecs[15] = mk(1'b1, 24, 1'b0, 1'b0, 1'b0, 3, 8, 3);
        for (int j = 0; j < 8; j++) begin
            vecs[16+j] = mk(1'b0, 0, 1'b0, 1'b1, 1'b1, 16 + j, 7 - j, 4 + j);
        end
        vecs[24] = mk(1'b0, 0, 1'b0, 1'b1, 1'b0, 23, 0, 11);
        vecs[25] = mk(1'b1, 33, 1'b1, 1'b1, 1'b0, 23, 0, 11);
        vecs[26] = mk(1'b1, 34, 1'b0, 1'b1, 1'b0, 23, 1, 11);
        vecs[27] = mk(1'b0, 0, 1'b0, 1'b1, 1'b1, 33, 1, 12);
        vecs[28] = mk(1'b0, 0, 1'b0, 1'b1, 1'b1, 34, 0, 13);
        vecs[29] = mk(1'b0, 0, 1'b0, 1'b1, 1'b0, 34, 0, 13);

        reset           = 1'b1;
        afu_req_valid   = 1'b0;
        afu_req_hdr     = {HW{1'b0}};
        fiu_c0TxAlmFull = 1'b0;
        #1;
        chk("rst_valid", 128'(fiu_c0Tx_valid), 128'(1'b0));
        chk("rst_hdr",   128'(fiu_c0Tx_hdr),   128'(0));
        chk("rst_occ",   128'(occupancy),      128'(0));
        chk("rst_cnt",   128'(issued_cnt),     128'(0));
        chk("rst_ready", 128'(afu_req_ready),  128'(1'b1));
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            afu_req_valid   = vecs[i].v;
            afu_req_hdr     = vecs[i].h;
            fiu_c0TxAlmFull = vecs[i].af;
            #1;
            chk($sformatf("v%0d_ready", i), 128'(afu_req_ready),  128'(vecs[i].e_rdy));
            chk($sformatf("v%0d_valid", i), 128'(fiu_c0Tx_valid), 128'(vecs[i].e_val));
            chk($sformatf("v%0d_hdr", i),   128'(fiu_c0Tx_hdr),   128'(vecs[i].e_hdr));
            chk($sformatf("v%0d_occ", i),   128'(occupancy),      128'(vecs[i].e_occ));
            chk($sformatf("v%0d_cnt", i),   128'(issued_cnt),     128'(vecs[i].e_cnt));
            @(negedge clk);
        end

        // Toggle almost-full every cycle while pushing, scoreboard the issued stream.
        exp_iss = 1'b0;
        exp_h   = {HW{1'b0}};
        nxt     = 0;
        pushed  = 0;
        for (int c = 0; c < 40; c++) begin
            chk("tog_valid", 128'(fiu_c0Tx_valid), 128'(exp_iss));
            if (exp_iss) begin
                chk("tog_hdr", 128'(fiu_c0Tx_hdr), 128'(exp_h));
            end
            fiu_c0TxAlmFull = (c < 24) ? c[0] : 1'b0;
            afu_req_valid   = (c < 24);
            afu_req_hdr     = HW'(32'h100 + nxt);
            #1;
            mdl_rdy = (mq.size() != 8);
            chk("tog_ready", 128'(afu_req_ready), 128'(mdl_rdy));
            exp_iss = (mq.size() != 0) && !fiu_c0TxAlmFull;
            if (exp_iss) begin
                exp_h = mq.pop_front();
            end
            if (afu_req_valid && mdl_rdy) begin
                mq.push_back(afu_req_hdr);
                nxt++;
                pushed++;
            end
            @(negedge clk);
        end
        chk("tog_last_valid", 128'(fiu_c0Tx_valid), 128'(exp_iss));
        chk("tog_drained", 128'(mq.size()), 128'(0));
        chk("tog_occ", 128'(occupancy), 128'(0));
        chk("tog_cnt", 128'(issued_cnt), 128'(13 + pushed));

        // Fill to 6 under almost-full, issue one, then reset mid-cycle at occupancy 5.
        fiu_c0TxAlmFull = 1'b1;
        for (int i = 0; i < 6; i++) begin
            afu_req_valid = 1'b1;
            afu_req_hdr   = HW'(32'h40 + i);
            @(negedge clk);
        end
        afu_req_valid   = 1'b0;
        fiu_c0TxAlmFull = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_occ",   128'(occupancy),      128'(5));
        chk("pre_rst_valid", 128'(fiu_c0Tx_valid), 128'(1'b1));
        #1;
        reset = 1'b1;
        #1;
        chk("arst_valid", 128'(fiu_c0Tx_valid), 128'(1'b0));
        chk("arst_hdr",   128'(fiu_c0Tx_hdr),   128'(0));
        chk("arst_occ",   128'(occupancy),      128'(0));
        chk("arst_cnt",   128'(issued_cnt),     128'(0));
        chk("arst_ready", 128'(afu_req_ready),  128'(1'b1));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_valid", 128'(fiu_c0Tx_valid), 128'(1'b0));
            chk("post_rst_occ",   128'(occupancy),      128'(0));
        end
        afu_req_valid = 1'b1;
        afu_req_hdr   = HW'(32'h55);
        @(negedge clk);
        afu_req_valid = 1'b0;
        chk("prst_push_valid", 128'(fiu_c0Tx_valid), 128'(1'b0));
        chk("prst_push_occ",   128'(occupancy),      128'(1));
        @(negedge clk);
        chk("prst_iss_valid", 128'(fiu_c0Tx_valid), 128'(1'b1));
        chk("prst_iss_hdr",   128'(fiu_c0Tx_hdr),   128'(32'h55));
        chk("prst_iss_cnt",   128'(issued_cnt),     128'(1));

        // Counter wrap: preload 0xFFFF then issue two requests.
        @(negedge clk);
        force dut.r_issued_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_issued_cnt;
        #1;
        chk("wrap_preload", 128'(issued_cnt), 128'(16'hFFFF));
        @(negedge clk);
        afu_req_valid = 1'b1;
        afu_req_hdr   = HW'(32'h61);
        @(negedge clk);
        afu_req_hdr   = HW'(32'h62);
        @(negedge clk);
        afu_req_valid = 1'b0;
        chk("wrap_mid", 128'(issued_cnt), 128'(16'h0000));
        @(negedge clk);
        @(negedge clk);
        chk("wrap_cnt", 128'(issued_cnt), 128'(16'h0001));
        chk("wrap_hdr", 128'(fiu_c0Tx_hdr), 128'(32'h62));

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
